// File: rtl/mem_block_copier.sv
// mem_block_copier: word-granular block-copy master for the single-cycle
// memory2c data memory. Copies num_words 16-bit words from src_addr to
// dst_addr in ascending order, alternating one READ and one WRITE cycle.
module mem_block_copier #(
    parameter int CNT_W        = 8,
    parameter bit DUMP_ON_DONE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      src_addr,
    input  logic [15:0]      dst_addr,
    input  logic [CNT_W-1:0] num_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             mem_enable,
    output logic             mem_wr,
    output logic             mem_createdump,
    input  logic [15:0]      mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      src_ptr;
    logic [15:0]      dst_ptr;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      hold;
    logic             err_q;

    // Either address odd means the request cannot be word-copied.
    logic misaligned;
    assign misaligned = src_addr[0] | dst_addr[0];

    // State register; reset parks the engine in IDLE.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: READ/WRITE alternate until the last word is written.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (misaligned || (num_words == '0)) state_nxt = DONE;
                    else                                 state_nxt = READ;
                end
            end
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = (cnt == CNT_W'(1)) ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the request, capture read data, advance pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
            hold    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err_q <= misaligned;
                        if (!misaligned) begin
                            src_ptr <= src_addr;
                            dst_ptr <= dst_addr;
                            cnt     <= num_words;
                        end
                    end
                end
                READ: hold <= mem_rdata;
                WRITE: begin
                    // 16-bit add wraps 0xFFFE to 0x0000 naturally.
                    src_ptr <= src_ptr + 16'd2;
                    dst_ptr <= dst_ptr + 16'd2;
                    cnt     <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Output decode from the registered state; everything is held at 0
    // while rst is high so an in-flight access is suppressed immediately.
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        err            = 1'b0;
        mem_addr       = 16'h0000;
        mem_wdata      = 16'h0000;
        mem_enable     = 1'b0;
        mem_wr         = 1'b0;
        mem_createdump = 1'b0;
        if (!rst) begin
            err = err_q;
            case (state)
                READ: begin
                    busy       = 1'b1;
                    mem_enable = 1'b1;
                    mem_addr   = src_ptr;
                end
                WRITE: begin
                    busy       = 1'b1;
                    mem_enable = 1'b1;
                    mem_wr     = 1'b1;
                    mem_addr   = dst_ptr;
                    mem_wdata  = hold;
                end
                DONE: begin
                    done           = 1'b1;
                    mem_createdump = DUMP_ON_DONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_copier.sv
// Directed bench for mem_block_copier with a word-wide memory model.
module tb_mem_block_copier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  num_words;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_enable;
    logic        mem_wr;
    logic        mem_createdump;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    mem_block_copier #(.CNT_W(8), .DUMP_ON_DONE(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .num_words(num_words),
        .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_createdump(mem_createdump), .mem_rdata(mem_rdata)
    );

    // Word memory indexed by byte address / 2; combinational read.
    logic [15:0] mem [0:32767];
    assign mem_rdata = mem[mem_addr[15:1]];
    always @(posedge clk) if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle log of one run, index = cycle number relative to start.
    localparam int MAXC = 16;
    logic        l_en [0:MAXC-1];
    logic        l_wr [0:MAXC-1];
    logic [15:0] l_addr [0:MAXC-1];
    logic [15:0] l_wdata [0:MAXC-1];
    logic        l_done [0:MAXC-1];
    logic        l_busy [0:MAXC-1];
    logic        l_err [0:MAXC-1];
    logic        l_dump [0:MAXC-1];

    // Cycle 0 carries start; cycles 1..maxc are logged at the falling edge.
    task automatic run(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n,
                       input int restart_c, input int rst_c, input int maxc);
        @(posedge clk); #1;
        start = 1'b1; src_addr = s; dst_addr = d; num_words = n;
        for (int c = 1; c <= maxc; c++) begin
            @(posedge clk); #1;
            start = (c == restart_c);
            rst   = (c == rst_c);
            @(negedge clk);
            l_en[c] = mem_enable; l_wr[c] = mem_wr; l_addr[c] = mem_addr;
            l_wdata[c] = mem_wdata; l_done[c] = done; l_busy[c] = busy;
            l_err[c] = err; l_dump[c] = mem_createdump;
        end
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
    endtask

    int done_cyc, ndone, nacc, nbusy, nclash, nnonzero;
    task automatic analyze(input int maxc, input int from_c);
        done_cyc = -1; ndone = 0; nacc = 0; nbusy = 0; nclash = 0; nnonzero = 0;
        for (int c = 1; c <= maxc; c++) begin
            if (l_done[c]) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (l_en[c]) nacc++;
            if (l_busy[c]) nbusy++;
            if (l_busy[c] && l_done[c]) nclash++;
            if (c >= from_c && (l_en[c] || l_wr[c] || l_addr[c] != 0 || l_wdata[c] != 0 ||
                l_done[c] || l_busy[c] || l_err[c] || l_dump[c])) nnonzero++;
        end
    endtask

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  n;
        int          exp_done;
        logic        exp_err;
        int          exp_acc;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [15:0] ea;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[16'h0010 >> 1] = 16'h1234;
        mem[16'h0012 >> 1] = 16'hABCD;
        mem[16'h0014 >> 1] = 16'h0F0F;
        mem[16'h0400 >> 1] = 16'h5555;
        mem[16'h0300 >> 1] = 16'h7777;
        mem[16'hFFFE >> 1] = 16'hAAAA;
        mem[16'h0000 >> 1] = 16'hBBBB;

        tbl[0] = '{16'h0010, 16'h0100, 8'd3, 7, 1'b0, 6};
        tbl[1] = '{16'h0200, 16'h0300, 8'd0, 1, 1'b0, 0};
        tbl[2] = '{16'h0011, 16'h0100, 8'd3, 1, 1'b1, 0};
        tbl[3] = '{16'h0010, 16'h0101, 8'd2, 1, 1'b1, 0};
        tbl[4] = '{16'h0400, 16'h0500, 8'd1, 3, 1'b0, 2};
        tbl[5] = '{16'hFFFE, 16'h2000, 8'd2, 5, 1'b0, 4};

        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; num_words = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {busy, done, err, mem_enable, mem_wr, mem_createdump}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_outputs", {busy, done, err, mem_enable, mem_wr, mem_addr, mem_wdata}, 0);

        for (int i = 0; i < 6; i++) begin
            run(tbl[i].src, tbl[i].dst, tbl[i].n, -1, -1, 12);
            analyze(12, 99);
            check($sformatf("v%0d_done_cyc", i), done_cyc, tbl[i].exp_done);
            check($sformatf("v%0d_done_cnt", i), ndone, 1);
            check($sformatf("v%0d_err_c1", i), l_err[1], tbl[i].exp_err);
            check($sformatf("v%0d_err_late", i), l_err[12], tbl[i].exp_err);
            check($sformatf("v%0d_accesses", i), nacc, tbl[i].exp_acc);
            check($sformatf("v%0d_busy_cycles", i), nbusy, tbl[i].exp_acc);
            check($sformatf("v%0d_busy_done", i), nclash, 0);
            if (!tbl[i].exp_err) begin
                for (int k = 0; k < int'(tbl[i].n); k++) begin
                    ea = tbl[i].src + 16'(2 * k);
                    check($sformatf("v%0d_rd%0d", i, k), {l_en[2*k+1], l_wr[2*k+1], l_addr[2*k+1]}, {2'b10, ea});
                    ea = tbl[i].dst + 16'(2 * k);
                    check($sformatf("v%0d_wr%0d", i, k), {l_en[2*k+2], l_wr[2*k+2], l_addr[2*k+2]}, {2'b11, ea});
                end
            end
        end
        check("copy3_w0", mem[16'h0100 >> 1], 16'h1234);
        check("copy3_w1", mem[16'h0102 >> 1], 16'hABCD);
        check("copy3_w2", mem[16'h0104 >> 1], 16'h0F0F);
        check("copy1_w0", mem[16'h0500 >> 1], 16'h5555);
        check("zero_untouched", mem[16'h0300 >> 1], 16'h7777);
        check("wrap_w0", mem[16'h2000 >> 1], 16'hAAAA);
        check("wrap_w1", mem[16'h2002 >> 1], 16'hBBBB);
        check("wrap_rd_addr_c3", l_addr[3], 16'h0000);

        // Reset in cycle 4 (WRITE of word 1) aborts the copy.
        mem[16'h3000 >> 1] = 16'h1111; mem[16'h3002 >> 1] = 16'h2222;
        mem[16'h3004 >> 1] = 16'h3333; mem[16'h3006 >> 1] = 16'h4444;
        run(16'h3000, 16'h3100, 8'd4, -1, 4, 10);
        analyze(10, 4);
        check("rstmid_outputs_zero", nnonzero, 0);
        check("rstmid_w0", mem[16'h3100 >> 1], 16'h1111);
        check("rstmid_w1", mem[16'h3102 >> 1], 16'h0000);
        check("rstmid_w2", mem[16'h3104 >> 1], 16'h0000);
        run(16'h3002, 16'h3200, 8'd1, -1, -1, 6);
        analyze(6, 99);
        check("rstmid_restart_done", done_cyc, 3);
        check("rstmid_restart_data", mem[16'h3200 >> 1], 16'h2222);

        // Overlapping ranges with a second start pulse in cycle 2.
        mem[0] = 16'hBEEF; mem[1] = 16'h0000; mem[2] = 16'h0000;
        run(16'h0000, 16'h0002, 8'd2, 2, -1, 10);
        analyze(10, 99);
        check("ovl_done_cyc", done_cyc, 5);
        check("ovl_done_cnt", ndone, 1);
        check("ovl_accesses", nacc, 4);
        check("ovl_w1", mem[1], 16'hBEEF);
        check("ovl_w2", mem[2], 16'hBEEF);
        check("ovl_wdata_c4", l_wdata[4], 16'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
